// File: rtl/scan_seq3.sv
// rtl/scan_seq3.sv - masked channel sweep sequencer driving a 3-to-8 decoder select
module scan_seq3 #(
    parameter int DW = 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          stop_i,
    input  logic          cont_i,
    input  logic [7:0]    mask_i,
    input  logic [DW-1:0] dwell_i,
    output logic [2:0]    x_o,
    output logic          e_o,
    output logic          busy_o,
    output logic          done_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    x_q, x_d;
    logic          e_q, e_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [7:0]    mask_q, mask_d;
    logic          cont_q, cont_d;

    // Lowest set bit of m; bit 3 of the result flags that any bit was set.
    function automatic logic [3:0] lowest_set(input logic [7:0] m);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Lowest set bit of m strictly above cur; bit 3 flags a hit (no hit means wrap).
    function automatic logic [3:0] next_above(input logic [7:0] m, input logic [2:0] cur);
        logic [3:0] r;
        r = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (3'(i) > cur)) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    logic [3:0] start_sel;
    logic [3:0] above_sel;
    logic [3:0] wrap_sel;

    // Channel selection candidates: first channel of a new sweep, next channel, wrapped channel.
    always_comb begin
        start_sel = lowest_set(mask_i);
        above_sel = next_above(mask_q, x_q);
        wrap_sel  = lowest_set(mask_q);
    end

    // Next-state and registered-output decode; STOP beats dwell end and wrap.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        e_d     = e_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        mask_d  = mask_q;
        cont_d  = cont_q;
        case (state_q)
            IDLE: begin
                x_d    = 3'd0;
                e_d    = 1'b0;
                busy_d = 1'b0;
                if (start_i && (mask_i != 8'h00)) begin
                    state_d = SCAN;
                    mask_d  = mask_i;
                    dwell_d = dwell_i;
                    cont_d  = cont_i;
                    x_d     = start_sel[2:0];
                    e_d     = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (stop_i) begin
                    state_d = IDLE;
                    x_d     = 3'd0;
                    e_d     = 1'b0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q == dwell_q) begin
                    cnt_d = '0;
                    if (above_sel[3]) begin
                        x_d = above_sel[2:0];
                    end else if (cont_q) begin
                        x_d = wrap_sel[2:0];
                    end else begin
                        state_d = IDLE;
                        x_d     = 3'd0;
                        e_d     = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            x_q     <= 3'd0;
            e_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            dwell_q <= '0;
            mask_q  <= 8'h00;
            cont_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            e_q     <= e_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
            mask_q  <= mask_d;
            cont_q  <= cont_d;
        end
    end

    assign x_o    = x_q;
    assign e_o    = e_q;
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: tb/tb_scan_seq3.sv
// tb/tb_scan_seq3.sv - scoreboard bench for scan_seq3
module tb_scan_seq3;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       cont;
    logic [7:0] mask;
    logic [3:0] dwell;
    logic [2:0] x;
    logic       e;
    logic       busy;
    logic       done;

    int n_tests;
    int n_fail;

    logic [5:0] sb_q[$];

    scan_seq3 #(.DW(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .start_i (start),
        .stop_i  (stop),
        .cont_i  (cont),
        .mask_i  (mask),
        .dwell_i (dwell),
        .x_o     (x),
        .e_o     (e),
        .busy_o  (busy),
        .done_o  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [5:0] pk(input int xv, input bit ev, input bit bv, input bit dv);
        return {3'(xv), ev, bv, dv};
    endfunction

    localparam logic [5:0] IDLE_EXP = 6'b000_000;
    localparam logic [5:0] DONE_EXP = 6'b000_001;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got {x,e,busy,done}=%0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the expectation, take one clock edge, then pop and compare the DUT output.
    task automatic cycle(input string tag, input logic [5:0] exp);
        logic [5:0] want;
        sb_q.push_back(exp);
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        check(tag, 32'({x, e, busy, done}), 32'(want));
    endtask

    task automatic set_in(input bit st, input bit sp, input bit c, input logic [7:0] m, input logic [3:0] d);
        start = st;
        stop  = sp;
        cont  = c;
        mask  = m;
        dwell = d;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        set_in(0, 0, 0, 8'h00, 4'd0);
        #12;
        check("reset_outputs", 32'({x, e, busy, done}), 32'(IDLE_EXP));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Multi-bit single sweep, two cycles per channel
        set_in(1, 0, 0, 8'b1010_0101, 4'd1);
        cycle("a5_x0a", pk(0, 1, 1, 0));
        start = 0;
        cycle("a5_x0b", pk(0, 1, 1, 0));
        cycle("a5_x2a", pk(2, 1, 1, 0));
        cycle("a5_x2b", pk(2, 1, 1, 0));
        cycle("a5_x5a", pk(5, 1, 1, 0));
        cycle("a5_x5b", pk(5, 1, 1, 0));
        cycle("a5_x7a", pk(7, 1, 1, 0));
        cycle("a5_x7b", pk(7, 1, 1, 0));
        cycle("a5_done", DONE_EXP);
        cycle("a5_idle", IDLE_EXP);

        // Single-bit continuous mask re-dwells, then STOP aborts without DONE
        set_in(1, 0, 1, 8'h10, 4'd0);
        cycle("h10_start", pk(4, 1, 1, 0));
        start = 0;
        for (int i = 0; i < 19; i++) cycle("h10_hold", pk(4, 1, 1, 0));
        stop = 1;
        cycle("h10_stop", IDLE_EXP);
        cycle("stop_in_idle", IDLE_EXP);
        stop = 0;
        cycle("h10_after", IDLE_EXP);

        // Empty mask ignored; then START with STOP in IDLE; START held across DONE edge
        set_in(1, 0, 0, 8'h00, 4'd0);
        for (int i = 0; i < 3; i++) cycle("mask0_ignored", IDLE_EXP);
        set_in(1, 1, 0, 8'h81, 4'd0);
        cycle("h81_x0", pk(0, 1, 1, 0));
        start = 0;
        stop  = 0;
        cycle("h81_x7", pk(7, 1, 1, 0));
        start = 1;
        cycle("h81_done", DONE_EXP);
        cycle("h81_restart", pk(0, 1, 1, 0));
        start = 0;
        stop  = 1;
        cycle("h81_stop", IDLE_EXP);
        stop = 0;

        // Live inputs ignored during a continuous full-mask sweep
        set_in(1, 0, 1, 8'hFF, 4'd3);
        cycle("ff_c0", pk(0, 1, 1, 0));
        set_in(0, 0, 0, 8'h01, 4'd0);
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 4; k++) begin
                if (ch != 0 || k != 0) begin
                    start = (ch == 2 && k == 1);
                    cycle("ff_sweep", pk(ch, 1, 1, 0));
                end
            end
        end
        start = 0;
        for (int k = 0; k < 4; k++) cycle("ff_wrap", pk(0, 1, 1, 0));
        stop = 1;
        cycle("ff_stop", IDLE_EXP);
        stop = 0;

        // Maximum dwell: 16 cycles on the only channel
        set_in(1, 0, 0, 8'h02, 4'd15);
        cycle("dmax_0", pk(1, 1, 1, 0));
        start = 0;
        for (int i = 1; i < 16; i++) cycle("dmax_hold", pk(1, 1, 1, 0));
        cycle("dmax_done", DONE_EXP);

        // Asynchronous reset mid-channel-3
        set_in(1, 0, 1, 8'h0C, 4'd2);
        cycle("h0c_x2a", pk(2, 1, 1, 0));
        start = 0;
        cycle("h0c_x2b", pk(2, 1, 1, 0));
        cycle("h0c_x2c", pk(2, 1, 1, 0));
        cycle("h0c_x3a", pk(3, 1, 1, 0));
        cycle("h0c_x3b", pk(3, 1, 1, 0));
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", 32'({x, e, busy, done}), 32'(IDLE_EXP));
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) cycle("post_reset", IDLE_EXP);

        // STOP coincides with dwell end and wrap on last channel
        set_in(1, 0, 0, 8'h03, 4'd0);
        cycle("h03_x0", pk(0, 1, 1, 0));
        start = 0;
        cycle("h03_x1", pk(1, 1, 1, 0));
        stop = 1;
        cycle("h03_stop_prio", IDLE_EXP);
        stop = 0;
        cycle("h03_idle", IDLE_EXP);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/scan_seq3.md
SCAN_SEQ3 -- requirements
Module: scan_seq3

Interface
REQ-001 Parameter: DW, default 4, width of dwell-length input and internal dwell counter.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  input  1  asynchronous, active-low reset.
REQ-004 START  input  1  sweep request; sampled on rising CLK.
REQ-005 STOP  input  1  abort request; sampled on rising CLK.
REQ-006 CONT  input  1  1 = continuous sweeping, 0 = single sweep; latched at accepted START.
REQ-007 MASK  input  8  channel enable bits, bit i enables channel i; latched at accepted START.
REQ-008 DWELL  input  DW  cycles-per-channel minus one; latched at accepted START.
REQ-009 X  output  3  registered channel select driving the downstream 3-to-8 decoder select.
REQ-010 E  output  1  registered decoder enable; 1 only while a channel is being driven.
REQ-011 BUSY  output  1  registered; 1 whenever state is SCAN.
REQ-012 DONE  output  1  registered one-cycle pulse marking completion of a single sweep.

Function
REQ-013 Two states: IDLE and SCAN; all outputs registered, no combinational input-to-output path.
REQ-014 IDLE: X=0, E=0, BUSY=0; DONE=0 except the pulse defined in REQ-021.
REQ-015 START accepted only in IDLE with MASK!=0; START in IDLE with MASK==0 ignored, no state change.
REQ-016 On accepted START edge: latch MASK, DWELL, CONT; enter SCAN; X = lowest-index set bit of MASK; E=1, BUSY=1 visible immediately after that edge; dwell counter cleared.
REQ-017 In SCAN each channel is held for exactly DWELL+1 cycles (DWELL=0 -> 1 cycle, DWELL=2^DW-1 -> 2^DW cycles).
REQ-018 At dwell end, X advances to the next set bit of the latched mask strictly above current X; if none, wraps to lowest set bit; dwell counter clears.
REQ-019 Wrap detected when the selected next index <= current X (includes single-bit mask case).
REQ-020 Wrap with CONT=1: continue in SCAN on wrapped channel; single-bit mask re-dwells on same channel indefinitely, E stays 1.
REQ-021 Wrap with CONT=0: enter IDLE on that edge; X=0, E=0, BUSY=0, DONE=1 for exactly one cycle.
REQ-022 STOP in SCAN has priority over dwell end and wrap: next edge enters IDLE, X=0, E=0, BUSY=0, DONE stays 0.
REQ-023 STOP in IDLE ignored; START and STOP both high in IDLE: START rule applies (STOP ignored).
REQ-024 START while in SCAN ignored; latched MASK/DWELL/CONT unchanged; live input changes during SCAN have no effect.
REQ-025 START high on the same edge DONE is asserted is ignored (state was SCAN); a new sweep requires START in a later IDLE cycle.
REQ-026 E=1 only while X names a channel whose latched mask bit is 1.

Reset
REQ-027 RST_N low forces, asynchronously, state IDLE, X=0, E=0, BUSY=0, DONE=0, dwell counter 0, latched MASK=0, DWELL=0, CONT=0.
REQ-028 Reset asserted mid-SCAN aborts without DONE; first edge after RST_N release behaves as IDLE.

Verification
REQ-029 MASK=8'b1010_0101, DWELL=1, CONT=0, START pulse -> X sequence 0,0,2,2,5,5,7,7 with E=1, then IDLE with DONE=1 for one cycle, E=0, X=0.
REQ-030 MASK=8'h10, DWELL=0, CONT=1, START -> X=4, E=1 held every cycle for 20 cycles; STOP pulse -> next edge E=0, BUSY=0, DONE=0.
REQ-031 MASK=8'h00, START -> BUSY stays 0, E stays 0; then MASK=8'h81, DWELL=0, CONT=0, START -> X=0,7 then DONE pulse.
REQ-032 MASK=8'hFF, DWELL=3, CONT=1, START, change MASK to 8'h01 and pulse START mid-sweep -> sweep continues 0..7 each held 4 cycles, wraps to 0, unaffected.
REQ-033 MASK=8'h0C, DWELL=2, CONT=1, assert RST_N low asynchronously between edges during channel 3 -> X=0, E=0, BUSY=0 immediately, no DONE after release.
REQ-034 MASK=8'h03, DWELL=0, CONT=0, STOP and dwell end coincide on channel 1 -> IDLE with DONE=0 (STOP priority).
